// File: rtl/sap_controller_if.sv
// Bus between the SAP-1 instruction register side and the control sequencer:
// opcode in, control word / ring counter / halt flag out.
interface sap_controller_if;
  logic [3:0]  opcode;
  logic [11:0] con;
  logic [5:0]  t_state;
  logic        halt;

  modport master (
    output opcode,
    input  con,
    input  t_state,
    input  halt
  );

  modport slave (
    input  opcode,
    output con,
    output t_state,
    output halt
  );
endinterface

// File: rtl/sap_controller.sv
// SAP-1 control sequencer: six-state one-hot ring counter plus combinational
// decode of the 12-bit control word from T-state and opcode.
module sap_controller (
  input  logic           clock,
  input  logic           reset,
  sap_controller_if.slave bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  tstate_e state_q, state_d;
  logic    halt_q, halt_d;
  opcode_e op;

  logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;

  assign op = opcode_e'(bus.opcode);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // HLT freezes the counter on T4 rather than advancing; only reset releases it.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (op == OP_HLT) halt_d  = 1'b1;
          else              state_d = T5;
        end
        T5: state_d = T6;
        T6: state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    ei_n = 1'b1;
    la_n = 1'b1;
    ea   = 1'b0;
    su   = 1'b0;
    eu   = 1'b0;
    lb_n = 1'b1;
    lo_n = 1'b1;
    if (reset && !halt_q) begin
      case (state_q)
        T1: begin
          ep   = 1'b1;
          lm_n = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_n = 1'b0;
          li_n = 1'b0;
        end
        T4: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB: begin
              ei_n = 1'b0;
              lm_n = 1'b0;
            end
            OP_OUT: begin
              ea   = 1'b1;
              lo_n = 1'b0;
            end
            default: ;
          endcase
        end
        T5: begin
          case (op)
            OP_LDA: begin
              ce_n = 1'b0;
              la_n = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ce_n = 1'b0;
              lb_n = 1'b0;
            end
            default: ;
          endcase
        end
        T6: begin
          case (op)
            OP_ADD: begin
              eu   = 1'b1;
              la_n = 1'b0;
            end
            OP_SUB: begin
              eu   = 1'b1;
              su   = 1'b1;
              la_n = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.con     = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n};
  assign bus.t_state = state_q;
  assign bus.halt    = halt_q;

endmodule

// File: tb/tb_sap_controller.sv
// Self-checking bench for sap_controller: instruction table, halt and
// asynchronous-reset sequences, then random opcodes/resets against a T-index model.
module tb_sap_controller;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  sap_controller_if bus ();

  sap_controller dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [11:0] c4;
    logic [11:0] c5;
    logic [11:0] c6;
  } vec_t;

  vec_t vecs [8];

  // Reference state: T index 1..6 and halted flag
  int   m_t;
  logic m_halt;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] onehot(input int t);
    logic [5:0] one;
    one = 6'b000001;
    return one << (t - 1);
  endfunction

  function automatic logic [11:0] fetch_word(input int t);
    case (t)
      1:       return 12'h5E3;
      2:       return 12'hBE3;
      default: return 12'h263;
    endcase
  endfunction

  function automatic logic [11:0] model_con(input int t, input logic [3:0] op,
                                            input logic halted, input logic rst);
    if (!rst || halted) return 12'h3E3;
    if (t <= 3) return fetch_word(t);
    case (op)
      4'h0: return (t == 4) ? 12'h1A3 : (t == 5) ? 12'h2C3 : 12'h3E3;
      4'h1: return (t == 4) ? 12'h1A3 : (t == 5) ? 12'h2E1 : 12'h3C7;
      4'h2: return (t == 4) ? 12'h1A3 : (t == 5) ? 12'h2E1 : 12'h3CF;
      4'hE: return (t == 4) ? 12'h3F2 : 12'h3E3;
      default: return 12'h3E3;
    endcase
  endfunction

  task automatic model_step(input logic [3:0] op);
    if (!m_halt) begin
      if (m_t == 4 && op == 4'hF) m_halt = 1'b1;
      else                        m_t = (m_t == 6) ? 1 : m_t + 1;
    end
  endtask

  // Called at a falling edge; leaves reset released at +1, design in T1.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, "_rst_tstate"}, 12'(bus.t_state), 12'h001);
    chk({tag, "_rst_halt"},   12'(bus.halt),    12'h000);
    chk({tag, "_rst_con"},    bus.con,          12'h3E3);
    reset = 1'b1;
  endtask

  // Starts in T1 just after a falling edge; fetch opcodes are random junk.
  task automatic run_instr(input vec_t v, input int idx);
    logic [11:0] exp;
    for (int t = 1; t <= 6; t++) begin
      bus.opcode = (t >= 4) ? v.op : 4'($urandom_range(0, 15));
      #1;
      case (t)
        4:       exp = v.c4;
        5:       exp = v.c5;
        6:       exp = v.c6;
        default: exp = fetch_word(t);
      endcase
      chk($sformatf("tbl%0d_op%h_T%0d_con", idx, v.op, t), bus.con, exp);
      chk($sformatf("tbl%0d_T%0d_tstate", idx, t), 12'(bus.t_state), 12'(onehot(t)));
      chk($sformatf("tbl%0d_T%0d_halt", idx, t), 12'(bus.halt), 12'h000);
      @(negedge clock);
    end
    chk($sformatf("tbl%0d_wrap_tstate", idx), 12'(bus.t_state), 12'h001);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      total++;
      if ($countones(bus.t_state) != 1) begin
        bad++;
        $display("FAIL onehot: got %b expected exactly one bit set", bus.t_state);
      end
    end
  end

  initial begin
    logic [3:0] op;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.opcode = 4'h0;

    vecs[0] = '{4'h0, 12'h1A3, 12'h2C3, 12'h3E3};
    vecs[1] = '{4'h1, 12'h1A3, 12'h2E1, 12'h3C7};
    vecs[2] = '{4'h2, 12'h1A3, 12'h2E1, 12'h3CF};
    vecs[3] = '{4'hE, 12'h3F2, 12'h3E3, 12'h3E3};
    vecs[4] = '{4'h5, 12'h3E3, 12'h3E3, 12'h3E3};
    vecs[5] = '{4'h3, 12'h3E3, 12'h3E3, 12'h3E3};
    vecs[6] = '{4'h8, 12'h3E3, 12'h3E3, 12'h3E3};
    vecs[7] = '{4'hD, 12'h3E3, 12'h3E3, 12'h3E3};

    // Reset held across several clock edges
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("init_tstate", 12'(bus.t_state), 12'h001);
    chk("init_halt",   12'(bus.halt),    12'h000);
    chk("init_con",    bus.con,          12'h3E3);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) run_instr(vecs[i], i);

    // HLT: halts at T4 and stays frozen while opcode toggles
    for (int t = 1; t <= 3; t++) begin
      bus.opcode = 4'($urandom_range(0, 15));
      @(negedge clock);
    end
    bus.opcode = 4'hF;
    #1;
    chk("hlt_T4_tstate", 12'(bus.t_state), 12'h008);
    chk("hlt_T4_con",    bus.con,          12'h3E3);
    chk("hlt_T4_halt",   12'(bus.halt),    12'h000);
    for (int e = 0; e < 10; e++) begin
      @(negedge clock);
      bus.opcode = ~bus.opcode;
      #1;
      chk($sformatf("hlt_e%0d_halt", e),   12'(bus.halt),    12'h001);
      chk($sformatf("hlt_e%0d_tstate", e), 12'(bus.t_state), 12'h008);
      chk($sformatf("hlt_e%0d_con", e),    bus.con,          12'h3E3);
    end
    @(negedge clock);
    do_reset("hlt");
    #1;
    chk("hlt_release_con", bus.con, 12'h5E3);

    // ADD interrupted by reset between edges of T5
    bus.opcode = 4'h1;
    repeat (4) @(negedge clock);
    chk("addrst_T5_con", bus.con, 12'h2E1);
    #2;
    reset = 1'b0;
    #1;
    chk("addrst_tstate", 12'(bus.t_state), 12'h001);
    chk("addrst_con",    bus.con,          12'h3E3);
    #1;
    reset = 1'b1;
    #0.5;
    chk("addrst_release_con", bus.con, 12'h5E3);
    @(negedge clock);
    chk("addrst_T2_tstate", 12'(bus.t_state), 12'h002);
    chk("addrst_T2_con",    bus.con,          12'hBE3);

    // Random opcodes and occasional resets against the model
    @(negedge clock);
    for (int n = 0; n < 600; n++) begin
      if (n == 0 || $urandom_range(0, 39) == 0) begin
        do_reset("rnd");
        m_t    = 1;
        m_halt = 1'b0;
      end
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
      bus.opcode = op;
      #1;
      chk($sformatf("rnd%0d_con", n),    bus.con,          model_con(m_t, op, m_halt, 1'b1));
      chk($sformatf("rnd%0d_tstate", n), 12'(bus.t_state), 12'(onehot(m_t)));
      chk($sformatf("rnd%0d_halt", n),   12'(bus.halt),    12'(m_halt));
      model_step(op);
      @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_controller.md
SAP_CONTROLLER -- requirements
Module: sap_controller

Interface
REQ-001 The block SHALL have port clock, input, 1 bit: system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-low; it clears all state immediately.
REQ-003 The block SHALL have port opcode, input, 4 bits: upper nibble of the instruction register, valid from T4 through T6.
REQ-004 The block SHALL have port con, output, 12 bits: control word, bit 11..0 = Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n.
REQ-005 The block SHALL have port t_state, output, 6 bits: one-hot ring counter, bit0 = T1 ... bit5 = T6.
REQ-006 The block SHALL have port halt, output, 1 bit: high once an HLT instruction has executed.
REQ-007 The block SHALL expose Lb_n and Lo_n as active-low and Ea as active-high, so that con[1], con[0] and con[4] connect directly to load_b, load_out and Ea of the datapath.

Function
REQ-008 The ring counter SHALL advance T1->T2->...->T6->T1 on each rising clock edge while halt=0.
REQ-009 The ring counter SHALL never hold more than one hot bit, and SHALL never hold zero hot bits.
REQ-010 The inactive word SHALL be 0x3E3: all active-low signals high, all active-high signals low.
REQ-011 The fetch words, independent of opcode, SHALL be: T1=0x5E3 (Ep, Lm_n); T2=0xBE3 (Cp); T3=0x263 (CE_n, Li_n).
REQ-012 LDA (0000) SHALL produce T4=0x1A3, T5=0x2C3, T6=0x3E3.
REQ-013 ADD (0001) SHALL produce T4=0x1A3, T5=0x2E1, T6=0x3C7.
REQ-014 SUB (0010) SHALL produce T4=0x1A3, T5=0x2E1, T6=0x3CF; Su SHALL be asserted only in SUB T6.
REQ-015 OUT (1110) SHALL produce T4=0x3F2 (Ea, Lo_n), T5=0x3E3, T6=0x3E3.
REQ-016 HLT (1111) and every undefined opcode SHALL produce 0x3E3 in T4, T5 and T6.
REQ-017 con SHALL be a combinational decode of t_state, opcode, halt and reset, with no added latency; it SHALL be stable for the whole T-state.
REQ-018 On the rising edge that ends T4 with opcode=1111, halt SHALL be set to 1 and t_state SHALL hold at T4.
REQ-019 While halt=1: t_state SHALL be frozen, con SHALL be 0x3E3, and opcode changes SHALL be ignored.
REQ-020 Only reset SHALL clear halt.
REQ-021 An undefined opcode SHALL behave as a NOP: full six-state cycle, then return to T1.
REQ-022 Opcode changes outside T4-T6 SHALL have no effect on con.

Reset
REQ-023 While reset=0, the outputs SHALL be: t_state=6'b000001, halt=0, con=0x3E3, regardless of clock.
REQ-024 Reset asserted mid-instruction, in any T-state or while halted, SHALL take effect immediately without waiting for a clock edge.
REQ-025 On the first rising edge after reset deasserts, t_state SHALL remain T1 for that edge's preceding cycle, with con=0x5E3 once reset=1; the next edge SHALL move to T2.

Verification
REQ-026 Release reset, opcode=0000, run 6 edges -> con sequence 0x5E3, 0xBE3, 0x263, 0x1A3, 0x2C3, 0x3E3, then t_state=000001.
REQ-027 opcode=0010, cycle T1-T6 -> con in T5=0x2E1 and T6=0x3CF; opcode=0001 -> T6=0x3C7.
REQ-028 opcode=1110 -> con in T4=0x3F2 (con[4]=1, con[0]=0); T5 and T6=0x3E3.
REQ-029 opcode=1111 at T4, then 10 further edges with opcode toggled -> halt=1, t_state=001000, con=0x3E3 throughout.
REQ-030 Pull reset low mid-T5 of an ADD, between edges -> t_state=000001, con=0x3E3 immediately; after release, con=0x5E3.
REQ-031 opcode=0101 -> con=0x3E3 in T4-T6 and the counter wraps to T1; a one-hot checker on t_state SHALL pass for all tests.
